// File: rtl/mau_pkg.sv
// Shared types and constants for the data-memory access unit.
package mau_pkg;

  localparam int unsigned WAIT_W = 4;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } mau_state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mau_req_t;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input logic [ADDR_W-1:0] lo,
                                         input logic [ADDR_W-1:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/mau_wait_counter.sv
// Loadable down-counter with a zero flag; times each memory access.
module mau_wait_counter
  import mau_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [WAIT_W-1:0] load_val_i,
  input  logic              dec_i,
  output logic [WAIT_W-1:0] count_o,
  output logic              zero_o
);

  logic [WAIT_W-1:0] count_q;
  logic [WAIT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WAIT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/data_mem_access_unit.sv
// Sequences one load/store at a time onto the DataMemory port.
// Optional address range check enabled by defining MAU_ADDR_CHECK_EN.
module data_mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned       WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] ADDR_LO     = 8'h00,
  parameter logic [ADDR_W-1:0] ADDR_HI     = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_fault,
  output logic              busy,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] ReadData
);

  localparam logic [WAIT_W-1:0] LOAD_VAL = WAIT_W'(WAIT_CYCLES - 1);

  if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15) || (ADDR_LO > ADDR_HI)) begin : g_param_err
    $error("data_mem_access_unit: illegal WAIT_CYCLES or address range");
  end

  mau_state_e        state_q;
  mau_req_t          req_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_fault_q;
  logic              rsp_valid_q;
  logic              req_ready_q;
  logic              busy_q;
  logic              mem_read_q;
  logic              mem_write_q;

  logic              addr_ok;
  logic              accept;
  logic              cnt_load;
  logic              cnt_dec;
  logic [WAIT_W-1:0] cnt;
  logic              cnt_zero;

`ifdef MAU_ADDR_CHECK_EN
  assign addr_ok = addr_in_range(req_addr, ADDR_LO, ADDR_HI);
`else
  assign addr_ok = 1'b1;
`endif

  assign accept   = (state_q == IDLE) && req_valid && req_ready_q;
  assign cnt_load = accept && addr_ok;
  assign cnt_dec  = (state_q == ACCESS) && !cnt_zero;

  mau_wait_counter u_wait_counter (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (cnt_load),
    .load_val_i (LOAD_VAL),
    .dec_i      (cnt_dec),
    .count_o    (cnt),
    .zero_o     (cnt_zero)
  );

  // Strobes are registered in phase with the state, so MemWrite is set one
  // edge ahead: on the edge where the counter moves to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      rsp_data_q  <= '0;
      rsp_fault_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            req_q       <= '{write: req_write, addr: req_addr, wdata: req_wdata};
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (!addr_ok) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_fault_q <= 1'b1;
              rsp_data_q  <= '0;
            end else begin
              state_q     <= ACCESS;
              rsp_fault_q <= 1'b0;
              mem_read_q  <= !req_write;
              mem_write_q <= req_write && (WAIT_CYCLES == 1);
            end
          end
        end
        ACCESS: begin
          if (cnt_zero) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= req_q.write ? '0 : ReadData;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end else begin
            mem_write_q <= req_q.write && (cnt == WAIT_W'(1));
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_fault = rsp_fault_q;
  assign busy      = busy_q;
  assign Address   = req_q.addr;
  assign WriteData = req_q.wdata;
  assign MemRead   = mem_read_q;
  assign MemWrite  = mem_write_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Bench for data_mem_access_unit: two instances (WAIT_CYCLES 1 and 3) against a
// word-array memory reference; range-check cases run when MAU_ADDR_CHECK_EN is defined.
module tb_data_mem_access_unit;

`ifdef MAU_ADDR_CHECK_EN
  localparam bit         CHECK_EN = 1'b1;
  localparam logic [7:0] LO       = 8'h00;
  localparam logic [7:0] HI       = 8'h7F;
`else
  localparam bit         CHECK_EN = 1'b0;
  localparam logic [7:0] LO       = 8'h00;
  localparam logic [7:0] HI       = 8'hFF;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_fault, busy;
  logic [1:0] MemRead, MemWrite;
  logic [7:0] req_addr [2];
  logic [7:0] req_wdata[2];
  logic [7:0] rsp_data [2];
  logic [7:0] Address  [2];
  logic [7:0] WriteData[2];
  logic [7:0] ReadData [2];

  logic [7:0] mem     [2][256];
  logic [7:0] ref_mem [2][256];
  int         mr_cnt[2];
  int         mw_cnt[2];
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    data_mem_access_unit #(
      .WAIT_CYCLES ((g == 0) ? 1 : 3),
      .ADDR_LO     (LO),
      .ADDR_HI     (HI)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_data  (rsp_data[g]),
      .rsp_fault (rsp_fault[g]),
      .busy      (busy[g]),
      .Address   (Address[g]),
      .WriteData (WriteData[g]),
      .MemRead   (MemRead[g]),
      .MemWrite  (MemWrite[g]),
      .ReadData  (ReadData[g])
    );
  end

  assign ReadData[0] = mem[0][Address[0]];
  assign ReadData[1] = mem[1][Address[1]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Simple synchronous-write, asynchronous-read DataMemory for each instance.
  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) begin
        logic [7:0] v;
        v = 8'($urandom);
        mem[k][i]     = v;
        ref_mem[k][i] = v;
      end
    end
    mem[1][255]     = 8'hC3;
    ref_mem[1][255] = 8'hC3;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (MemWrite[k]) mem[k][Address[k]] <= WriteData[k];
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (MemRead[k]) mr_cnt[k]++;
      if (MemWrite[k]) mw_cnt[k]++;
      if (MemRead[k] || MemWrite[k]) chk("rd_wr_exclusive", 32'(MemRead[k] & MemWrite[k]), 0);
    end
  end

  task automatic do_txn(input int k, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, input int stall);
    int         wc, mr0, mw0, edges;
    logic       f;
    logic [7:0] exp_d;
    wc    = (k == 0) ? 1 : 3;
    f     = CHECK_EN && ((a < LO) || (a > HI));
    exp_d = (wr || f) ? 8'h00 : ref_mem[k][a];
    chk("req_ready_idle", 32'(req_ready[k]), 1);
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k]  = a;
    req_wdata[k] = d;
    mr0 = mr_cnt[k];
    mw0 = mw_cnt[k];
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    chk("busy_after_accept", 32'(busy[k]), 1);
    chk("req_ready_after_accept", 32'(req_ready[k]), 0);
    if (!f) begin
      chk("addr_driven", 32'(Address[k]), 32'(a));
      if (wr) chk("wdata_driven", 32'(WriteData[k]), 32'(d));
    end
    edges = 0;
    while (!rsp_valid[k] && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    // Edges after the accept edge; counting the handshake cycle this is WAIT_CYCLES+1.
    chk("latency_edges", 32'(edges), f ? 0 : 32'(wc));
    for (int i = 0; i < stall; i++) begin
      chk("rsp_valid_hold", 32'(rsp_valid[k]), 1);
      chk("rsp_data_hold", 32'(rsp_data[k]), 32'(exp_d));
      chk("req_ready_in_resp", 32'(req_ready[k]), 0);
      req_valid[k] = 1'b1;
      req_write[k] = 1'b0;
      req_addr[k]  = a ^ 8'h01;
      @(posedge clk); #1;
    end
    req_valid[k] = 1'b0;
    chk("rsp_valid", 32'(rsp_valid[k]), 1);
    chk("rsp_data", 32'(rsp_data[k]), 32'(exp_d));
    chk("rsp_fault", 32'(rsp_fault[k]), 32'(f));
    chk("memread_cycles", 32'(mr_cnt[k] - mr0), (wr || f) ? 0 : 32'(wc));
    chk("memwrite_pulses", 32'(mw_cnt[k] - mw0), (wr && !f) ? 1 : 0);
    rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[k] = 1'b0;
    chk("rsp_valid_clear", 32'(rsp_valid[k]), 0);
    chk("busy_clear", 32'(busy[k]), 0);
    chk("req_ready_back", 32'(req_ready[k]), 1);
    if (wr && !f) begin
      ref_mem[k][a] = d;
      chk("mem_written", 32'(mem[k][a]), 32'(d));
    end
  endtask

  initial begin
    logic [7:0] prev;
    int         mw0;
    rst       = 1'b0;
    req_valid = '0;
    req_write = '0;
    rsp_ready = '0;
    for (int k = 0; k < 2; k++) begin
      req_addr[k]  = '0;
      req_wdata[k] = '0;
    end
    #23;
    for (int k = 0; k < 2; k++) begin
      chk("reset_req_ready", 32'(req_ready[k]), 1);
      chk("reset_busy", 32'(busy[k]), 0);
      chk("reset_rsp_valid", 32'(rsp_valid[k]), 0);
      chk("reset_memread", 32'(MemRead[k]), 0);
      chk("reset_memwrite", 32'(MemWrite[k]), 0);
      chk("reset_address", 32'(Address[k]), 0);
      chk("reset_rsp_fault", 32'(rsp_fault[k]), 0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    do_txn(0, 1'b1, 8'h10, 8'h5A, 0);
    do_txn(0, 1'b0, 8'h10, 8'h00, 0);
    do_txn(1, 1'b0, 8'hFF, 8'h00, 0);
    do_txn(0, 1'b0, 8'h10, 8'h00, 4);
    do_txn(1, 1'b1, 8'h40, 8'h96, 4);

    prev = ref_mem[1][8'h20];
    mw0  = mw_cnt[1];
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_addr[1]  = 8'h20;
    req_wdata[1] = ~prev;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("midstore_memwrite_c1", 32'(MemWrite[1]), 0);
    @(posedge clk); #1;
    chk("midstore_memwrite_c2", 32'(MemWrite[1]), 0);
    rst = 1'b0;
    #1;
    chk("midstore_rst_memwrite", 32'(MemWrite[1]), 0);
    chk("midstore_rst_busy", 32'(busy[1]), 0);
    chk("midstore_rst_req_ready", 32'(req_ready[1]), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midstore_mem_unchanged", 32'(mem[1][8'h20]), 32'(prev));
    chk("midstore_no_write", 32'(mw_cnt[1] - mw0), 0);
    chk("midstore_idle", 32'(busy[1]), 0);
    do_txn(1, 1'b0, 8'h20, 8'h00, 0);

`ifdef MAU_ADDR_CHECK_EN
    do_txn(0, 1'b0, 8'h80, 8'h00, 1);
    do_txn(0, 1'b0, 8'h7F, 8'h00, 0);
    do_txn(1, 1'b1, 8'hFF, 8'h11, 0);
`endif

    for (int n = 0; n < 24; n++) begin
      int         k;
      logic       wr;
      logic [7:0] a;
      k  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       a = 8'hFF;
        1:       a = 8'h00;
        2:       a = 8'h10;
        default: a = 8'($urandom);
      endcase
      do_txn(k, wr, a, 8'($urandom), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
